// File: rtl/mips_cp0_pkg.sv
// mips_cp0_pkg: shared definitions for the CP0 register file.
//   - CP0 register numbers (the rd field of mfc0/mtc0)
//   - ExcCode values written into Cause.ExcCode
//   - Status/Cause field bit positions and mtc0 write masks
//   - read-word composition helpers for Status and Cause
package mips_cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Status field positions
  localparam int STATUS_BEV    = 22;
  localparam int STATUS_IM_LSB = 8;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IE     = 0;

  // Cause field positions
  localparam int CAUSE_BD        = 31;
  localparam int CAUSE_TI        = 30;
  localparam int CAUSE_IPHW_LSB  = 10;
  localparam int CAUSE_IPSW_LSB  = 8;
  localparam int CAUSE_EXC_LSB   = 2;

  // Bits an mtc0 is allowed to change
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Status as seen by mfc0: BEV is hard-wired to 1, unlisted bits read 0.
  function automatic logic [31:0] status_word(input logic [7:0] im,
                                              input logic       exl,
                                              input logic       ie);
    logic [31:0] w;
    w                            = '0;
    w[STATUS_BEV]                = 1'b1;
    w[STATUS_IM_LSB +: 8]        = im;
    w[STATUS_EXL]                = exl;
    w[STATUS_IE]                 = ie;
    return w;
  endfunction

  // Cause as seen by mfc0.
  function automatic logic [31:0] cause_word(input logic       bd,
                                             input logic       ti,
                                             input logic [5:0] ip_hw,
                                             input logic [1:0] ip_sw,
                                             input logic [4:0] exc);
    logic [31:0] w;
    w                           = '0;
    w[CAUSE_BD]                 = bd;
    w[CAUSE_TI]                 = ti;
    w[CAUSE_IPHW_LSB +: 6]      = ip_hw;
    w[CAUSE_IPSW_LSB +: 2]      = ip_sw;
    w[CAUSE_EXC_LSB +: 5]       = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer of CP0.
//   clk, rst (async, active-low)
//   count_we / compare_we / wdata : mtc0 writes to registers 9 / 11
//   count, compare                : current register values
//   ti                            : timer interrupt flag (Cause.TI)
// Count advances every second cycle; TI is sticky until Compare is written.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;
  logic match;

  assign match = (count == compare) && (compare != 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick    <= 1'b0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      tick <= ~tick;
      // An explicit write wins over this cycle's increment; wrap is natural.
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      // Writing Compare is the only way to acknowledge the timer interrupt.
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (match) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 register file and exception/eret sequencer.
//   clk, rst (async, active-low)
//   CP0WrEn/addr/wdata   : mtc0 commit
//   CP0Rd/addr -> rdata  : mfc0 read (combinational, 0 when not reading)
//   Exception/ExcCode/isBD/pc/bad_addr : exception commit
//   eret_flush           : eret commit
//   hw_int               : external level-sensitive interrupt lines
//   Interrupt            : enabled pending interrupt to the decoder
//   flush/redirect_pc    : same-cycle fetch redirect
//   epc_out              : current EPC
// Priority when strobes coincide: Exception > eret_flush > CP0WrEn; the
// losers are dropped for that cycle.
module cp0_regfile
  import mips_cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CP0WrEn,
  input  logic        CP0Rd,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        Exception,
  input  logic [4:0]  ExcCode,
  input  logic        isBD,
  input  logic        eret_flush,
  input  logic [31:0] pc,
  input  logic [31:0] bad_addr,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic        Interrupt,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_out
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic [4:0]  cause_exc;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic        wr_ok;
  logic        addr_exc;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [7:0]  ip_all;

  // mtc0 only lands when no higher-priority commit occupies the cycle.
  assign wr_ok    = CP0WrEn & ~Exception & ~eret_flush;
  assign addr_exc = (ExcCode == EXC_ADEL) || (ExcCode == EXC_ADES);

  assign status_rd = status_word(status_im, status_exl, status_ie);
  assign cause_rd  = cause_word(cause_bd, ti, cause_ip_hw, cause_ip_sw, cause_exc);
  assign ip_all    = {cause_ip_hw, cause_ip_sw};

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_ok && (addr == CP0_COUNT)),
    .compare_we (wr_ok && (addr == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Architectural state update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_im   <= STATUS_RST[STATUS_IM_LSB +: 8];
      status_exl  <= STATUS_RST[STATUS_EXL];
      status_ie   <= STATUS_RST[STATUS_IE];
      cause_bd    <= 1'b0;
      cause_exc   <= '0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      epc         <= '0;
      badvaddr    <= '0;
    end else begin
      // Timer interrupt is folded onto the top hardware line.
      cause_ip_hw <= {hw_int[5] | ti, hw_int[4:0]};
      if (Exception) begin
        status_exl <= 1'b1;
        cause_exc  <= ExcCode;
        // A nested exception must not lose the original return point.
        if (!status_exl) begin
          epc      <= isBD ? (pc - 32'd4) : pc;
          cause_bd <= isBD;
        end
        if (addr_exc)
          badvaddr <= bad_addr;
      end else if (eret_flush) begin
        status_exl <= 1'b0;
      end else if (wr_ok) begin
        case (addr)
          CP0_STATUS: begin
            status_im  <= wdata[STATUS_IM_LSB +: 8];
            status_exl <= wdata[STATUS_EXL];
            status_ie  <= wdata[STATUS_IE];
          end
          CP0_CAUSE: cause_ip_sw <= wdata[CAUSE_IPSW_LSB +: 2];
          CP0_EPC:   epc         <= wdata;
          default: ;
        endcase
      end
    end
  end

  // mfc0 read mux
  always_comb begin
    rdata = '0;
    if (CP0Rd) begin
      case (addr)
        CP0_BADVADDR: rdata = badvaddr;
        CP0_COUNT:    rdata = count;
        CP0_COMPARE:  rdata = compare;
        CP0_STATUS:   rdata = status_rd;
        CP0_CAUSE:    rdata = cause_rd;
        CP0_EPC:      rdata = epc;
        default:      rdata = '0;
      endcase
    end
  end

  assign Interrupt   = status_ie & ~status_exl & (|(ip_all & status_im));
  assign flush       = Exception | eret_flush;
  assign redirect_pc = Exception ? EXC_VECTOR : epc;
  assign epc_out     = epc;

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file and exception/return sequencer for the 5-stage MIPS core. It consumes the exception and privileged-instruction controls produced by the decoder: `Exception`, `ExcCode`, `isBD`, `eret_flush`, `CP0WrEn` and `CP0Rd`. It holds BadVAddr, Count, Compare, Status, Cause and EPC. It drives the `Interrupt` request back to the decoder and the PC redirect (flush plus target) to the fetch stage.

## Interface
- `EXC_VECTOR`, 32'hBFC0_0380, exception entry address
- `STATUS_RST`, 32'h0040_0000, Status reset value (BEV=1)
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `CP0WrEn`  in  1  mtc0 commit strobe
- `CP0Rd`  in  1  mfc0 in progress (qualifies `rdata`)
- `addr`  in  5  CP0 register number (rd field)
- `wdata`  in  32  mtc0 data
- `Exception`  in  1  exception commit strobe
- `ExcCode`  in  5  cause code for `Exception`
- `isBD`  in  1  faulting instruction is in a delay slot
- `eret_flush`  in  1  eret commit strobe
- `pc`  in  32  PC of the committing instruction
- `bad_addr`  in  32  faulting address for AdEL/AdES
- `hw_int`  in  6  external interrupt lines, level-sensitive
- `rdata`  out  32  mfc0 read data
- `Interrupt`  out  1  pending, enabled interrupt
- `flush`  out  1  redirect fetch and squash younger stages
- `redirect_pc`  out  32  redirect target
- `epc_out`  out  32  current EPC

## Operation
- Register fields. All fields not listed below read 0.
  - Status: BEV[22] is read-only 1. IM[15:8], EXL[1] and IE[0] are writable.
  - Cause: BD[31] and TI[30] are read-only. IP[15:10] is hardware-driven. IP[9:8] is software-writable. ExcCode[6:2].
  - EPC, Count and Compare: fully writable.
  - BadVAddr: read-only.
- Read path: `rdata` is a combinational mux on `addr`. It returns 0 when `CP0Rd`=0 or for an unimplemented register number.
- mtc0: on the clock edge with `CP0WrEn`=1, write the addressed register through its writable-field mask. Writing Compare also clears TI.
- Exception entry, on the clock edge with `Exception`=1:
  - EXL<=1 and ExcCode<=`ExcCode`.
  - Only if the old EXL=0: EPC<=`isBD` ? `pc`-4 : `pc`, and BD<=`isBD`.
  - If `ExcCode` is AdEL (5'h04) or AdES (5'h05): BadVAddr<=`bad_addr`.
- eret: on the clock edge with `eret_flush`=1 (and `Exception`=0), EXL<=0.
- Priority in one cycle: `Exception` > `eret_flush` > `CP0WrEn`. A lower-priority request in the same cycle is dropped entirely.
- Interrupt sampling: Cause.IP[15:10] <= {hw_int[5] | TI, hw_int[4:0]} every cycle.
- Interrupt output: `Interrupt` = IE & ~EXL & |(Cause.IP[15:8] & Status.IM[15:8]). It is combinational from registers.
- Redirect:
  - `flush` = `Exception` | `eret_flush`, combinational.
  - `redirect_pc` = `Exception` ? `EXC_VECTOR` : EPC, where EPC is the pre-edge value.
- Timer:
  - A 1-bit `tick` toggles every cycle. Count increments when `tick`=1, i.e. every second cycle, and wraps from 32'hFFFF_FFFF to 0.
  - TI is set on the edge where Count == Compare and Compare != 0. It is sticky until Compare is written.
  - An mtc0 to Count overrides that cycle's increment.

## Timing
- Reset (asynchronous, `rst`=0):
  - Status=`STATUS_RST`.
  - Cause, EPC, Count, Compare, BadVAddr and `tick` = 0.
  - Outputs: `Interrupt`=0, `flush`=0 (given inputs low), `rdata`=0, `epc_out`=0.
- Register state updates on the edge following the strobe. `flush`/`redirect_pc` are valid in the same cycle as the strobe.
- An mfc0 in the cycle after an mtc0 to the same register reads the new value. There is no internal bypass; the pipeline guarantees ordering.
- Nested exception (EXL=1): EPC and BD are held; ExcCode still updates.
- Reset asserted mid-operation aborts everything: no partial EPC or Status update survives.
- `Interrupt` drops in the cycle after the entry edge, because EXL has become 1.

## Structure
- Package `mips_cp0_pkg` holds:
  - CP0 register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
  - ExcCode constants: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - Status/Cause field bit positions and write masks.
- Sub-module `cp0_timer`: Count, Compare, `tick` and TI logic, with mtc0 ports for registers 9/11.

## Test plan
- Exception in a delay slot: `pc`=32'hBFC0_0104, `isBD`=1, `ExcCode`=8 (Sys).
  - `flush`=1 and `redirect_pc`=32'hBFC0_0380 in the same cycle.
  - Next cycle: EPC=32'hBFC0_0100, Cause=32'h8000_0020, EXL=1.
- mtc0 Status=32'h0000_FF01, then `hw_int`=6'b000001.
  - Two cycles later `Interrupt`=1 and Cause[10]=1.
  - After an `Exception` with `ExcCode`=0, `Interrupt`=0.
- AdEL with `bad_addr`=32'h0000_0003: BadVAddr=32'h0000_0003 on the next edge, and mfc0 of register 8 returns it.
- Nested exception: with EXL=1, assert `Exception` at `pc`=32'h100. EPC is unchanged and ExcCode is updated.
- eret together with `CP0WrEn` to EPC=32'h200 in the same cycle:
  - `redirect_pc` = the old EPC.
  - Next cycle: EXL=0 and EPC is unchanged (write dropped).
- Timer: Compare=10 and Count=0.
  - TI=1 after about 20 cycles, and Cause.IP7=1.
  - Writing Compare=50 clears TI on the next edge.
